instr_mem_responder: RTL and testbench

- Responder end of the instruction-fetch interface: accepts word-address requests from the fetch stage and returns the 32-bit instruction together with the echoed address.
- Sits between the fetch stage and instruction storage. Models configurable read latency with a valid/ready handshake on both request and response.
- Holds a word-addressed instruction store, preloaded through a side load port by benches and boot logic.

---
 rtl/instr_mem_responder.sv | 132 +++++++++++++
 tb/tb_instr_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// instr_mem_responder
//   Responder end of the instruction-fetch interface. Accepts one word-address
//   request at a time from the fetch stage and returns the 32-bit instruction
//   and the echoed request address after a fixed, parameterised latency.
//   The instruction store can be preloaded through a side load port.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
//   where valid and ready are both high. The producer holds valid and its
//   payload stable until that edge. Here req_ready is a pure function of the
//   registered state. rsp_valid/rsp_data/rsp_addr/rsp_err are held until the
//   edge where rsp_ready is high.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_addr                   byte address of requested instruction
//   rsp_valid/rsp_ready        response handshake
//   rsp_data                   instruction word (0 on error)
//   rsp_addr                   address of the request being answered
//   rsp_err                    misaligned or out-of-range request
//   load_en/load_idx/load_data side write port into the store, any state
//   fsm_state                  debug view of the control state (0 idle, 1 wait, 2 resp)
module instr_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_idx,
  input  logic [31:0]           load_data,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  accept, capture;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  addr_err;
  logic [31:0]           store [DEPTH];

  assign req_ready = (state == S_IDLE);
  assign fsm_state = state;

  // Address decode of the latched request.
  assign word_idx = lat_addr[DEPTH_LOG2+1:2];
  assign addr_err = (|lat_addr[1:0]) | (|lat_addr[ADDR_WIDTH-1:DEPTH_LOG2+2]);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          // The accept edge itself counts as the first latency cycle.
          cnt_nx   = 4'(LATENCY - 1);
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = S_RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lat_addr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) lat_addr <= req_addr;
    end
  end

  // Response registers: loaded on capture, rsp_valid dropped on handshake,
  // payload holds its last value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_data  <= addr_err ? 32'd0 : store[word_idx];
      rsp_addr  <= lat_addr;
      rsp_err   <= addr_err;
    end else if (state == S_RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Store is not reset. A load on the capture edge lands after the read
  // above samples the old word, giving read-before-write.
  always_ff @(posedge clk) begin
    if (load_en) store[load_idx] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder
//   Three responders (LATENCY 2, 4 and 1) with independent stimulus.
//   A transaction-level model predicts every output each cycle. Directed
//   sequences add hand-computed literal checks.
module tb_instr_mem_responder;

  localparam int N = 3;
  localparam int LAT_TAB [N] = '{2, 4, 1};

  logic        clk;
  logic        rst_n;
  logic        req_valid [N];
  logic        req_ready [N];
  logic [31:0] req_addr  [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_data  [N];
  logic [31:0] rsp_addr  [N];
  logic        rsp_err   [N];
  logic        load_en   [N];
  logic [7:0]  load_idx  [N];
  logic [31:0] load_data [N];
  logic [1:0]  fsm_state [N];

  int n_tests = 0;
  int n_fail  = 0;
  bit run     = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_mem_responder #(
      .ADDR_WIDTH(32),
      .DEPTH_LOG2(8),
      .LATENCY   (LAT_TAB[g])
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_data (rsp_data[g]),
      .rsp_addr (rsp_addr[g]),
      .rsp_err  (rsp_err[g]),
      .load_en  (load_en[g]),
      .load_idx (load_idx[g]),
      .load_data(load_data[g]),
      .fsm_state(fsm_state[g])
    );
  end

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A request accepted at some edge answers exactly LAT edges later, the
  // answer sits until handshaken, and nothing is accepted meanwhile.
  logic [31:0] m_mem   [N][256];
  logic        m_pend  [N];
  int          m_left  [N];
  logic [31:0] m_lat   [N];
  logic        m_valid [N];
  logic [31:0] m_data  [N];
  logic [31:0] m_addr  [N];
  logic        m_err   [N];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_pend[i]  = 1'b0;
        m_left[i]  = 0;
        m_valid[i] = 1'b0;
        m_data[i]  = 32'd0;
        m_addr[i]  = 32'd0;
        m_err[i]   = 1'b0;
      end else begin
        if (m_valid[i]) begin
          if (rsp_ready[i]) m_valid[i] = 1'b0;
        end else if (m_pend[i]) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_err[i]   = (m_lat[i] % 4 != 0) || (m_lat[i] >= 32'd1024);
            m_data[i]  = m_err[i] ? 32'd0 : m_mem[i][m_lat[i] / 4];
            m_addr[i]  = m_lat[i];
            m_valid[i] = 1'b1;
            m_pend[i]  = 1'b0;
          end
        end else if (req_valid[i]) begin
          m_pend[i] = 1'b1;
          m_left[i] = LAT_TAB[i];
          m_lat[i]  = req_addr[i];
        end
        if (load_en[i]) m_mem[i][load_idx[i]] = load_data[i];
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (run) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d.req_ready", i), 32'(req_ready[i]), 32'(!m_pend[i] && !m_valid[i]));
        chk($sformatf("u%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(m_valid[i]));
        chk($sformatf("u%0d.rsp_data", i), rsp_data[i], m_data[i]);
        chk($sformatf("u%0d.rsp_addr", i), rsp_addr[i], m_addr[i]);
        chk($sformatf("u%0d.rsp_err", i), 32'(rsp_err[i]), 32'(m_err[i]));
      end
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int i, input int idx, input logic [31:0] d);
    load_en[i]   = 1'b1;
    load_idx[i]  = 8'(idx);
    load_data[i] = d;
    step();
    load_en[i] = 1'b0;
  endtask

  // Full request/response transaction with rsp_ready high.
  task automatic fetch(input int i, input logic [31:0] a,
                       output logic [31:0] d, output logic e, output logic [31:0] ra);
    int k;
    d  = 32'hx;
    e  = 1'bx;
    ra = 32'hx;
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    for (k = 0; k < 50 && !req_ready[i]; k++) step();
    if (!req_ready[i]) begin
      timeout("fetch.accept");
      req_valid[i] = 1'b0;
      return;
    end
    step();
    req_valid[i] = 1'b0;
    for (k = 0; k < 40 && !rsp_valid[i]; k++) step();
    if (!rsp_valid[i]) begin
      timeout("fetch.response");
      return;
    end
    d  = rsp_data[i];
    e  = rsp_err[i];
    ra = rsp_addr[i];
    step();
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d, ra;
  logic        e;
  int          cnt;

  initial begin
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'd0;
      rsp_ready[i] = 1'b1;
      load_en[i]   = 1'b0;
      load_idx[i]  = 8'd0;
      load_data[i] = 32'd0;
    end
    rst_n = 1'b0;

    // Reset / idle
    @(posedge clk);
    run = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset.req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset.rsp_data", rsp_data[0], 32'd0);
    chk("reset.rsp_addr", rsp_addr[0], 32'd0);
    chk("reset.rsp_err", 32'(rsp_err[0]), 32'd0);
    step();

    // Basic fetch, LATENCY=2
    load_word(0, 3, 32'h8C220004);
    load_word(0, 255, 32'hDEADBEEF);
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000000C;
    step();                                  // edge N: accept
    req_valid[0] = 1'b0;
    chk("basic.busy", 32'(req_ready[0]), 32'd0);
    step();                                  // N+1
    chk("basic.n1_valid", 32'(rsp_valid[0]), 32'd0);
    step();                                  // N+2
    chk("basic.n2_valid", 32'(rsp_valid[0]), 32'd1);
    chk("basic.data", rsp_data[0], 32'h8C220004);
    chk("basic.addr", rsp_addr[0], 32'h0000000C);
    chk("basic.err", 32'(rsp_err[0]), 32'd0);
    step();                                  // N+3: handshake
    chk("basic.n3_valid", 32'(rsp_valid[0]), 32'd0);
    chk("basic.n3_ready", 32'(req_ready[0]), 32'd1);

    // Backpressure
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000000C;
    step();
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid[0]; k++) step();
    if (!rsp_valid[0]) timeout("bp.response");
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h000003FC;
    for (int k = 0; k < 5; k++) begin
      chk("bp.hold_valid", 32'(rsp_valid[0]), 32'd1);
      chk("bp.hold_data", rsp_data[0], 32'h8C220004);
      chk("bp.hold_addr", rsp_addr[0], 32'h0000000C);
      chk("bp.no_accept", 32'(req_ready[0]), 32'd0);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();                                  // handshake edge
    chk("bp.hs_valid", 32'(rsp_valid[0]), 32'd0);
    chk("bp.hs_ready", 32'(req_ready[0]), 32'd1);
    step();                                  // second request accepted
    chk("bp.second_accepted", 32'(req_ready[0]), 32'd0);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid[0]; k++) step();
    if (!rsp_valid[0]) timeout("bp.second_response");
    chk("bp.second_data", rsp_data[0], 32'hDEADBEEF);
    chk("bp.second_addr", rsp_addr[0], 32'h000003FC);
    step();

    // Errors and top-of-store boundary
    fetch(0, 32'h00000006, d, e, ra);
    chk("err.misaligned_err", 32'(e), 32'd1);
    chk("err.misaligned_data", d, 32'd0);
    chk("err.misaligned_addr", ra, 32'h00000006);
    fetch(0, 32'h00000400, d, e, ra);
    chk("err.range_err", 32'(e), 32'd1);
    chk("err.range_data", d, 32'd0);
    fetch(0, 32'h000003FC, d, e, ra);
    chk("err.top_err", 32'(e), 32'd0);
    chk("err.top_data", d, 32'hDEADBEEF);

    // Mid-operation reset, LATENCY=4
    load_word(1, 4, 32'hA5A50004);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h00000010;
    step();                                  // accept
    req_valid[1] = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (rsp_valid[1]) cnt++;
      step();
    end
    chk("rst.no_response", 32'(cnt), 32'd0);
    fetch(1, 32'h00000010, d, e, ra);
    chk("rst.refetch_data", d, 32'hA5A50004);

    // Throughput with request held, LATENCY=4: one per 6 cycles
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h00000010;
    cnt = 0;
    for (int k = 0; k < 18; k++) begin
      step();
      if (rsp_valid[1]) cnt++;
    end
    req_valid[1] = 1'b0;
    chk("tput.responses", 32'(cnt), 32'd3);
    repeat (8) step();

    // Load/read collision, LATENCY=1
    load_word(2, 5, 32'h11111111);
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h00000014;
    step();                                  // edge N: accept
    req_valid[2] = 1'b0;
    load_en[2]   = 1'b1;
    load_idx[2]  = 8'd5;
    load_data[2] = 32'h22222222;
    step();                                  // N+1: capture + write
    load_en[2] = 1'b0;
    chk("coll.valid", 32'(rsp_valid[2]), 32'd1);
    chk("coll.old_data", rsp_data[2], 32'h11111111);
    step();
    fetch(2, 32'h00000014, d, e, ra);
    chk("coll.new_data", d, 32'h22222222);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
